// File: rtl/mul_issue_stage.sv
// Two-stage issue/retire wrapper around an external unsigned N x N array multiplier.
// S1 registers operand magnitudes and signs; S2 sign-corrects the array product and selects the half.
module mul_issue_stage #(
    parameter int N     = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [N-1:0]     arr_a,
    output logic [N-1:0]     arr_b,
    input  logic [N-1:0]     arr_hi,
    input  logic [N-1:0]     arr_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [TAG_W-1:0] tag;
        logic             neg_a;
        logic             neg_b;
        logic [N-1:0]     mag_a;
        logic [N-1:0]     mag_b;
    } s1_t;

    s1_t              s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [N-1:0]     res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             s2_free, advance, accept;
    logic             neg_a_in, neg_b_in;
    logic [2*N-1:0]   prod, prod_c;

    assign s2_free  = !s2_valid_q || out_ready;
    assign advance  = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = in_valid && in_ready && !flush;

    assign neg_a_in = in_a[N-1] && ((in_op == OP_MULH) || (in_op == OP_MULHSU));
    assign neg_b_in = in_b[N-1] && (in_op == OP_MULH);

    // Array sees unsigned magnitudes; sign is reapplied to the full 2N-bit product.
    assign prod   = {arr_hi, arr_lo};
    assign prod_c = (s1_q.neg_a ^ s1_q.neg_b) ? (~prod + 1'b1) : prod;

    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        tag_d      = tag_q;

        if (accept) begin
            s1_d.op    = op_e'(in_op);
            s1_d.tag   = in_tag;
            s1_d.neg_a = neg_a_in;
            s1_d.neg_b = neg_b_in;
            s1_d.mag_a = neg_a_in ? (~in_a + 1'b1) : in_a;
            s1_d.mag_b = neg_b_in ? (~in_b + 1'b1) : in_b;
        end

        if (advance && !flush) begin
            res_d = (s1_q.op == OP_MUL) ? prod_c[N-1:0] : prod_c[2*N-1:N];
            tag_d = s1_q.tag;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept)         s1_valid_d = 1'b1;
            else if (advance)   s1_valid_d = 1'b0;
            if (advance)        s2_valid_d = 1'b1;
            else if (out_ready) s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            tag_q      <= '0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            tag_q      <= tag_d;
        end
    end

    assign arr_a      = s1_q.mag_a;
    assign arr_b      = s1_q.mag_b;
    assign out_valid  = s2_valid_q;
    assign out_result = res_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_mul_issue_stage.sv
// Directed and randomized checks of mul_issue_stage against an arithmetic RV32M model.
module tb_mul_issue_stage;

    localparam int N = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = '0;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [N-1:0]     arr_a, arr_b, arr_hi, arr_lo;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N-1:0]     out_result;
    logic [TAG_W-1:0] out_tag;
    logic [63:0]      arr_prod;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational array.
    assign arr_prod = 64'(arr_a) * 64'(arr_b);
    assign arr_hi   = arr_prod[63:32];
    assign arr_lo   = arr_prod[31:0];

    mul_issue_stage #(.N(N), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .arr_a(arr_a), .arr_b(arr_b), .arr_hi(arr_hi), .arr_lo(arr_lo),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] xa, xb, p;
        xa = (op == 2'b01 || op == 2'b10) ? 66'($signed(a)) : $signed({34'b0, a});
        xb = (op == 2'b01) ? 66'($signed(b)) : $signed({34'b0, b});
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = t;
    endtask

    logic [36:0] q[$];
    logic [36:0] exp_e;
    logic        acc, cons;
    int          accepted, cyc;

    initial begin
        #2;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_arr", {arr_a, arr_b}, 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        #5 rst_n = 1'b1;
        tick();

        // MUL 7 * -3, latency and tag echo
        drive(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd9);
        tick();
        in_valid = 1'b0;
        check("mul_lat_s1", 64'(out_valid), 64'd0);
        tick();
        check("mul_lat_s2", 64'(out_valid), 64'd1);
        check("mul_result", 64'(out_result), 64'hFFFF_FFEB);
        check("mul_tag", 64'(out_tag), 64'd9);
        tick();
        check("mul_drained", 64'(out_valid), 64'd0);

        // MULH most-negative squared
        drive(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3);
        tick();
        in_valid = 1'b0;
        check("mulh_arr", {arr_a, arr_b}, 64'h8000_0000_8000_0000);
        tick();
        check("mulh_result", 64'(out_result), 64'h4000_0000);

        // MULHSU then MULHU back to back on all-ones operands
        drive(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        tick();
        drive(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        tick();
        in_valid = 1'b0;
        check("mulhsu_result", {27'b0, out_tag, out_result}, {27'b0, 5'd1, 32'hFFFF_FFFF});
        tick();
        check("mulhu_result", {27'b0, out_tag, out_result}, {27'b0, 5'd2, 32'hFFFF_FFFE});
        tick();

        // Backpressure
        out_ready = 1'b0;
        drive(2'b00, 32'd2, 32'd3, 5'd4);
        tick();
        drive(2'b00, 32'd4, 32'd5, 5'd5);
        tick();
        drive(2'b00, 32'd6, 32'd7, 5'd6);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_hold_a", {31'b0, out_valid, out_result}, {31'b0, 1'b1, 32'd6});
        tick();
        check("bp_hold_b", {31'b0, out_valid, out_result}, {31'b0, 1'b1, 32'd6});
        check("bp_arr_stable", {arr_a, arr_b}, {32'd4, 32'd5});
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", 64'(in_ready), 64'd1);
        check("bp_r0", 64'(out_result), 64'd6);
        tick();
        in_valid = 1'b0;
        check("bp_r1", {31'b0, out_valid, out_result}, {31'b0, 1'b1, 32'd20});
        tick();
        check("bp_r2", {31'b0, out_valid, out_result}, {31'b0, 1'b1, 32'd42});
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush with both stages full plus an accepted-looking offer
        out_ready = 1'b0;
        drive(2'b00, 32'd11, 32'd13, 5'd7);
        tick();
        drive(2'b00, 32'd17, 32'd19, 5'd8);
        tick();
        out_ready = 1'b1;
        flush = 1'b1;
        drive(2'b00, 32'd23, 32'd29, 5'd10);
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_nothing_later", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        drive(2'b00, 32'd3, 32'd5, 5'd11);
        tick();
        drive(2'b00, 32'd9, 32'd9, 5'd12);
        tick();
        in_valid = 1'b0;
        check("prereset_full", {31'b0, out_valid, out_result}, {31'b0, 1'b1, 32'd15});
        #2 rst_n = 1'b0;
        #1;
        check("areset_out", {31'b0, out_valid, out_result}, 64'd0);
        check("areset_arr", {arr_a, arr_b}, 64'd0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("after_reset_empty", 64'(out_valid), 64'd0);

        // Randomized traffic against the queue model
        accepted = 0;
        cyc = 0;
        while (accepted < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 499) == 0);
            in_op     = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: in_a = 32'h8000_0000;
                1: in_a = 32'hFFFF_FFFF;
                default: in_a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: in_b = 32'h8000_0000;
                1: in_b = 32'd0;
                default: in_b = $urandom;
            endcase
            in_tag = 5'($urandom);
            #3;
            acc  = in_valid && in_ready && !flush;
            cons = out_valid && out_ready;
            if (cons) begin
                if (q.size() == 0) begin
                    check("rand_spurious", {27'b0, out_tag, out_result}, 64'hDEAD);
                end else begin
                    exp_e = q.pop_front();
                    check("rand_result", {27'b0, out_tag, out_result}, {27'b0, exp_e});
                end
            end
            if (flush) q.delete();
            else if (acc) begin
                q.push_back({in_tag, ref_mul(in_op, in_a, in_b)});
                accepted++;
            end
            tick();
            cyc++;
        end
        check("rand_budget", 64'(accepted), 64'd10000);

        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            #3;
            if (out_valid) begin
                exp_e = q.pop_front();
                check("drain_result", {27'b0, out_tag, out_result}, {27'b0, exp_e});
            end
            tick();
            cyc++;
        end
        check("drain_queue_empty", 64'(q.size()), 64'd0);
        check("drain_out_idle", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
